// File: rtl/alu_issue_stage.sv
// Issue stage in front of alu_32: decodes MIPS alu_op/funct, fires a one-cycle
// start pulse, waits for alu_finished (bounded by a timeout) and holds the result.
module alu_issue_stage #(
    parameter int WORD_SIZE      = 32,
    parameter int TIMEOUT_CYCLES = 4
) (
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           in_alu_op,
    input  logic [5:0]           in_funct,
    input  logic [WORD_SIZE-1:0] in_a,
    input  logic [WORD_SIZE-1:0] in_b,

    output logic                 alu_start,
    output logic [WORD_SIZE-1:0] alu_input_a,
    output logic [WORD_SIZE-1:0] alu_input_b,
    output logic [3:0]           alu_control,
    input  logic                 alu_finished,
    input  logic                 alu_zero,
    input  logic                 alu_err_overflow,
    input  logic                 alu_err_invalid_control,
    input  logic [WORD_SIZE-1:0] alu_result,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_result,
    output logic                 out_zero,
    output logic                 out_overflow,
    output logic                 out_err_decode,
    output logic                 out_err_timeout
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 start_q, start_d;
    logic [WORD_SIZE-1:0] a_q, a_d;
    logic [WORD_SIZE-1:0] b_q, b_d;
    logic [3:0]           ctrl_q, ctrl_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 valid_q, valid_d;
    logic [WORD_SIZE-1:0] result_q, result_d;
    logic                 zero_q, zero_d;
    logic                 ovf_q, ovf_d;
    logic                 dec_err_q, dec_err_d;
    logic                 tmo_q, tmo_d;

    logic [3:0]           dec_ctrl;
    logic                 dec_err;
    logic                 ovf_allowed;

    // MIPS main-decoder alu_op plus R-type funct to alu_32 control code.
    always_comb begin
        dec_ctrl = 4'h0;
        dec_err  = 1'b0;
        case (in_alu_op)
            2'b00: dec_ctrl = 4'h2;
            2'b01: dec_ctrl = 4'h6;
            2'b11: dec_ctrl = 4'h1;
            default: begin
                case (in_funct)
                    6'b100000: dec_ctrl = 4'h2;
                    6'b100001: dec_ctrl = 4'h3;
                    6'b100010: dec_ctrl = 4'h6;
                    6'b100100: dec_ctrl = 4'h0;
                    6'b100101: dec_ctrl = 4'h1;
                    6'b100111: dec_ctrl = 4'hC;
                    6'b101010: dec_ctrl = 4'h7;
                    default:   dec_err  = 1'b1;
                endcase
            end
        endcase
    end

    // Only signed add/sub can trap; addu (code 3) never reports overflow.
    assign ovf_allowed = (ctrl_q == 4'h2) || (ctrl_q == 4'h6);

    always_comb begin
        state_d   = state_q;
        start_d   = 1'b0;
        a_d       = a_q;
        b_d       = b_q;
        ctrl_d    = ctrl_q;
        cnt_d     = cnt_q;
        valid_d   = valid_q;
        result_d  = result_q;
        zero_d    = zero_q;
        ovf_d     = ovf_q;
        dec_err_d = dec_err_q;
        tmo_d     = tmo_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d = in_a;
                    b_d = in_b;
                    if (dec_err) begin
                        ctrl_d    = 4'h0;
                        result_d  = '0;
                        zero_d    = 1'b0;
                        ovf_d     = 1'b0;
                        dec_err_d = 1'b1;
                        tmo_d     = 1'b0;
                        valid_d   = 1'b1;
                        state_d   = S_DONE;
                    end else begin
                        ctrl_d  = dec_ctrl;
                        start_d = 1'b1;
                        cnt_d   = '0;
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (alu_finished) begin
                    result_d  = alu_result;
                    zero_d    = alu_zero;
                    ovf_d     = ovf_allowed & alu_err_overflow;
                    dec_err_d = alu_err_invalid_control;
                    tmo_d     = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    result_d  = '0;
                    zero_d    = 1'b0;
                    ovf_d     = 1'b0;
                    dec_err_d = 1'b0;
                    tmo_d     = 1'b1;
                    valid_d   = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                if (out_ready) begin
                    valid_d   = 1'b0;
                    ovf_d     = 1'b0;
                    dec_err_d = 1'b0;
                    tmo_d     = 1'b0;
                    state_d   = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            start_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            ctrl_q    <= 4'h0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
            ovf_q     <= 1'b0;
            dec_err_q <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ctrl_q    <= ctrl_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            ovf_q     <= ovf_d;
            dec_err_q <= dec_err_d;
            tmo_q     <= tmo_d;
        end
    end

    assign in_ready        = (state_q == S_IDLE);
    assign alu_start       = start_q;
    assign alu_input_a     = a_q;
    assign alu_input_b     = b_q;
    assign alu_control     = ctrl_q;
    assign out_valid       = valid_q;
    assign out_result      = result_q;
    assign out_zero        = zero_q;
    assign out_overflow    = ovf_q;
    assign out_err_decode  = dec_err_q;
    assign out_err_timeout = tmo_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a registered alu_32 stand-in that
// answers one cycle after seeing alu_start.
module tb_alu_issue_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_alu_op;
    logic [5:0]  in_funct;
    logic [31:0] in_a, in_b;
    logic        alu_start;
    logic [31:0] alu_input_a, alu_input_b;
    logic [3:0]  alu_control;
    logic        alu_finished, alu_zero, alu_err_overflow, alu_err_invalid_control;
    logic [31:0] alu_result;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_zero, out_overflow, out_err_decode, out_err_timeout;

    int n_checks = 0;
    int n_err    = 0;
    int start_cnt = 0;
    int start_base;
    int n;
    logic stub_en  = 1'b1;
    logic stub_ovf = 1'b0;

    always #5 clock = ~clock;

    alu_issue_stage #(.WORD_SIZE(32), .TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_alu_op(in_alu_op),
        .in_funct(in_funct), .in_a(in_a), .in_b(in_b),
        .alu_start(alu_start), .alu_input_a(alu_input_a), .alu_input_b(alu_input_b),
        .alu_control(alu_control), .alu_finished(alu_finished), .alu_zero(alu_zero),
        .alu_err_overflow(alu_err_overflow), .alu_err_invalid_control(alu_err_invalid_control),
        .alu_result(alu_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_zero(out_zero), .out_overflow(out_overflow),
        .out_err_decode(out_err_decode), .out_err_timeout(out_err_timeout)
    );

    // Stand-in for alu_32: result registered the cycle after a start pulse.
    always @(posedge clock) begin
        if (reset) begin
            alu_finished            <= 1'b0;
            alu_result              <= '0;
            alu_zero                <= 1'b0;
            alu_err_overflow        <= 1'b0;
            alu_err_invalid_control <= 1'b0;
        end else begin
            logic [31:0] r;
            case (alu_control)
                4'h0: r = alu_input_a & alu_input_b;
                4'h1: r = alu_input_a | alu_input_b;
                4'h2, 4'h3: r = alu_input_a + alu_input_b;
                4'h6: r = alu_input_a - alu_input_b;
                4'h7: r = ($signed(alu_input_a) < $signed(alu_input_b)) ? 32'd1 : 32'd0;
                4'hC: r = ~(alu_input_a | alu_input_b);
                default: r = '0;
            endcase
            alu_finished            <= alu_start & stub_en;
            alu_result              <= r;
            alu_zero                <= (r == 32'd0);
            alu_err_overflow        <= stub_ovf;
            alu_err_invalid_control <= 1'b0;
        end
    end

    always @(posedge clock) if (alu_start) start_cnt <= start_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one request at a negedge; returns half a cycle after the handshake edge.
    task automatic send(input logic [1:0] op, input logic [5:0] fn,
                        input logic [31:0] a, input logic [31:0] b);
        in_alu_op = op; in_funct = fn; in_a = a; in_b = b;
        in_valid  = 1'b1;
        @(negedge clock);
        in_valid  = 1'b0;
    endtask

    // Counts negedges until out_valid, bounded at 20.
    task automatic wait_valid(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            @(negedge clock);
            cycles++;
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_alu_op = 2'b00; in_funct = '0;
        in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alu_start", 32'(alu_start), 32'd0);
        chk("rst_alu_control", 32'(alu_control), 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_flags", {28'd0, out_zero, out_overflow, out_err_decode, out_err_timeout}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // ADD 5+7
        start_base = start_cnt;
        send(2'b00, 6'd0, 32'd5, 32'd7);
        chk("add_start_hi", 32'(alu_start), 32'd1);
        chk("add_ctrl", 32'(alu_control), 32'h2);
        chk("add_in_ready", 32'(in_ready), 32'd0);
        wait_valid(n);
        chk("add_latency", 32'(n), 32'd2);
        chk("add_result", out_result, 32'd12);
        chk("add_zero_ovf", {30'd0, out_zero, out_overflow}, 32'd0);
        chk("add_start_cycles", 32'(start_cnt - start_base), 32'd1);
        $display("txn ADD 5+7 -> result=%0d latency=%0d", out_result, n);
        @(negedge clock);
        chk("add_release", {30'd0, out_valid, in_ready}, 32'b01);

        // SUB overflow
        stub_ovf = 1'b1;
        send(2'b10, 6'b100010, 32'h8000_0000, 32'd1);
        chk("sub_ctrl", 32'(alu_control), 32'h6);
        wait_valid(n);
        chk("sub_ovf", 32'(out_overflow), 32'd1);
        chk("sub_ovf_result", out_result, 32'h7FFF_FFFF);
        $display("txn SUB 80000000-1 -> result=%0h ovf=%0d", out_result, out_overflow);
        @(negedge clock);
        stub_ovf = 1'b0;

        // SUB zero
        send(2'b10, 6'b100010, 32'd9, 32'd9);
        wait_valid(n);
        chk("sub_zero_result", out_result, 32'd0);
        chk("sub_zero_flag", 32'(out_zero), 32'd1);
        $display("txn SUB 9-9 -> result=%0h zero=%0d", out_result, out_zero);
        @(negedge clock);

        // ADDU masks overflow
        stub_ovf = 1'b1;
        send(2'b10, 6'b100001, 32'hFFFF_FFFF, 32'd1);
        chk("addu_ctrl", 32'(alu_control), 32'h3);
        wait_valid(n);
        chk("addu_result", out_result, 32'd0);
        chk("addu_zero", 32'(out_zero), 32'd1);
        chk("addu_ovf_masked", 32'(out_overflow), 32'd0);
        $display("txn ADDU ffffffff+1 -> result=%0h ovf=%0d", out_result, out_overflow);
        @(negedge clock);
        stub_ovf = 1'b0;

        // Decode error
        start_base = start_cnt;
        send(2'b10, 6'b000000, 32'd1, 32'd2);
        wait_valid(n);
        chk("dec_latency", 32'(n), 32'd0);
        chk("dec_err_flag", 32'(out_err_decode), 32'd1);
        chk("dec_result", out_result, 32'd0);
        chk("dec_no_start", 32'(start_cnt - start_base), 32'd0);
        $display("txn DECODE-ERR funct=0 -> err_decode=%0d", out_err_decode);
        @(negedge clock);
        chk("dec_err_cleared", 32'(out_err_decode), 32'd0);

        // SLT 3<4
        send(2'b10, 6'b101010, 32'd3, 32'd4);
        chk("slt_ctrl", 32'(alu_control), 32'h7);
        wait_valid(n);
        chk("slt_result", out_result, 32'd1);
        $display("txn SLT 3<4 -> result=%0d", out_result);
        @(negedge clock);

        // OR via alu_op 11
        send(2'b11, 6'd0, 32'h0000_00F0, 32'h0000_000F);
        chk("or_ctrl", 32'(alu_control), 32'h1);
        wait_valid(n);
        chk("or_result", out_result, 32'h0000_00FF);
        $display("txn OR f0|0f -> result=%0h", out_result);
        @(negedge clock);

        // Backpressure: held result, inputs ignored while busy
        out_ready = 1'b0;
        send(2'b00, 6'd0, 32'd1, 32'd2);
        wait_valid(n);
        in_valid = 1'b1; in_a = 32'd100; in_b = 32'd200;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_result", out_result, 32'd3);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            @(negedge clock);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clock);
        chk("bp_release", {30'd0, out_valid, in_ready}, 32'b01);
        $display("txn ADD 1+2 backpressure -> result held, released");

        // Timeout
        stub_en = 1'b0;
        send(2'b00, 6'd0, 32'd4, 32'd4);
        wait_valid(n);
        chk("tmo_latency", 32'(n), 32'd5);
        chk("tmo_flag", 32'(out_err_timeout), 32'd1);
        chk("tmo_result", out_result, 32'd0);
        $display("txn ADD timeout -> err_timeout=%0d after %0d", out_err_timeout, n);
        @(negedge clock);
        chk("tmo_cleared", 32'(out_err_timeout), 32'd0);

        // Reset in WAIT
        send(2'b00, 6'd0, 32'd6, 32'd6);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("rw_in_ready", 32'(in_ready), 32'd1);
        chk("rw_out_valid", 32'(out_valid), 32'd0);
        chk("rw_alu_start", 32'(alu_start), 32'd0);
        chk("rw_operands", alu_input_a | alu_input_b, 32'd0);
        chk("rw_flags", {28'd0, out_zero, out_overflow, out_err_decode, out_err_timeout}, 32'd0);
        reset   = 1'b0;
        stub_en = 1'b1;
        @(negedge clock);
        send(2'b00, 6'd0, 32'd10, 32'd20);
        wait_valid(n);
        chk("post_rst_latency", 32'(n), 32'd2);
        chk("post_rst_result", out_result, 32'd30);
        $display("txn ADD 10+20 after reset -> result=%0d", out_result);
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
